sha256_msg_padder: RTL and testbench

//   Upstream feeder for the SHA-256 compression core. Reads an NUM_OF_WORDS-word message from word-addressed

---
 rtl/sha256_pkg.sv | 34 +++
 rtl/sha256_msg_padder.sv | 118 +++++++++++
 tb/tb_sha256_msg_padder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, padding constants and
// the block-count / pad-word helpers used by the padder and the core's tests.
package sha256_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  // Number of 512-bit blocks needed for n_words of message plus the marker
  // bit and the 64-bit length field.
  function automatic int unsigned sha256_num_blocks(input int unsigned n_words);
    return (32 * n_words + 65 + 511) / 512;
  endfunction

  // Value of global word g when g lies past the message body: the marker
  // word right after the message, the bit length in the very last word and
  // zero everywhere else (including the upper length half).
  function automatic logic [31:0] sha256_pad_word(input int unsigned g,
                                                  input int unsigned n_words,
                                                  input int unsigned nb);
    logic [31:0] w;
    w = '0;
    if (g == n_words) begin
      w = PAD_WORD;
    end else if (g == 16 * nb - 1) begin
      w = 32'(32 * n_words);
    end
    return w;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads a NUM_OF_WORDS-word message from word-addressed memory, applies
// SHA-256 padding and hands the result out one 512-bit block at a time.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  input_addr,
  output logic         busy,
  output logic         done,
  output logic         memory_clk,
  output logic         enable_write,
  output logic [15:0]  memory_addr,
  input  logic [31:0]  memory_read_data,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [511:0] block_data,
  output logic         block_last
);

  localparam int unsigned NW = NUM_OF_WORDS;
  localparam int unsigned NB = sha256_num_blocks(NW);

  logic [1:0]  state;
  logic [15:0] base_addr;
  logic [31:0] blk;
  logic [4:0]  k;
  logic [31:0] buffer [16];
  logic [3:0]  wr_ptr;
  logic [31:0] g;
  logic [31:0] word_in;
  logic [15:0] fetch_addr;

  assign memory_clk   = clk;
  assign enable_write = 1'b0;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  // The address register plus the one-cycle memory latency put each word
  // two FETCH steps behind its address, so step k stores word k-2.
  assign wr_ptr     = 4'(k - 5'd2);
  assign g          = {blk[27:0], 4'b0000} + {28'd0, wr_ptr};
  assign word_in    = (g < NW) ? memory_read_data : sha256_pad_word(g, NW, NB);
  assign fetch_addr = base_addr + {blk[11:0], 4'b0000} + {11'd0, k};

  // Flatten the word buffer so word 0 lands in the top 32 bits.
  always_comb begin
    block_data = '0;
    for (int j = 0; j < 16; j++) begin
      block_data[511 - 32 * j -: 32] = buffer[j];
    end
  end

  // Control FSM, read address generation and buffer fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base_addr   <= '0;
      blk         <= '0;
      k           <= '0;
      memory_addr <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            base_addr <= input_addr;
            blk       <= '0;
            k         <= '0;
          end
        end
        ST_FETCH: begin
          if (k <= 5'd15) begin
            memory_addr <= fetch_addr;
          end
          if (k >= 5'd2) begin
            buffer[wr_ptr] <= word_in;
          end
          if (k == 5'd17) begin
            state       <= ST_PRESENT;
            block_valid <= 1'b1;
            block_last  <= (blk == 32'(NB - 1));
          end else begin
            k <= k + 5'd1;
          end
        end
        ST_PRESENT: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            if (block_last) begin
              state <= ST_DONE;
            end else begin
              blk   <= blk + 32'd1;
              k     <= '0;
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: three instances (N=40, 14, 16)
// share clock, reset and ready; a memory model returns mem[a] = a.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [15:0] addr_in;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic         start_w [3];
  logic         busy_w  [3];
  logic         done_w  [3];
  logic         mclk_w  [3];
  logic         we_w    [3];
  logic [15:0]  maddr_w [3];
  logic [31:0]  rdata_w [3];
  logic         valid_w [3];
  logic [511:0] data_w  [3];
  logic         last_w  [3];

  int n_of  [3] = '{40, 14, 16};
  int nb_of [3] = '{3, 2, 2};

  // Free-running clock.
  always #5 clk = ~clk;

  // Only the selected instance sees the start pulse.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      start_w[i] = start && (sel == i);
    end
  end

  // Registered-read memory: data for last cycle's address, mem[a] = a.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rdata_w[i] <= {16'h0000, maddr_w[i]};
    end
  end

  sha256_msg_padder #(.NUM_OF_WORDS(40)) dut40 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .input_addr(addr_in),
    .busy(busy_w[0]), .done(done_w[0]), .memory_clk(mclk_w[0]),
    .enable_write(we_w[0]), .memory_addr(maddr_w[0]),
    .memory_read_data(rdata_w[0]), .block_valid(valid_w[0]),
    .block_ready(ready), .block_data(data_w[0]), .block_last(last_w[0]));

  sha256_msg_padder #(.NUM_OF_WORDS(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .input_addr(addr_in),
    .busy(busy_w[1]), .done(done_w[1]), .memory_clk(mclk_w[1]),
    .enable_write(we_w[1]), .memory_addr(maddr_w[1]),
    .memory_read_data(rdata_w[1]), .block_valid(valid_w[1]),
    .block_ready(ready), .block_data(data_w[1]), .block_last(last_w[1]));

  sha256_msg_padder #(.NUM_OF_WORDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .input_addr(addr_in),
    .busy(busy_w[2]), .done(done_w[2]), .memory_clk(mclk_w[2]),
    .enable_write(we_w[2]), .memory_addr(maddr_w[2]),
    .memory_read_data(rdata_w[2]), .block_valid(valid_w[2]),
    .block_ready(ready), .block_data(data_w[2]), .block_last(last_w[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checkOutput(tag, {480'd0, obs}, {480'd0, exp});
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {511'd0, obs}, {511'd0, exp});
  endtask

  function automatic logic [31:0] wordOf(input logic [511:0] d, input int j);
    return d[511 - 32 * j -: 32];
  endfunction

  // Reference padded block built directly from the padding rules.
  function automatic logic [511:0] expBlock(input int n, input int nb,
                                            input logic [15:0] base,
                                            input int blk);
    logic [511:0] r;
    logic [31:0]  w;
    int           g;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      g = 16 * blk + j;
      if (g < n)                w = {16'h0000, base + 16'(g)};
      else if (g == n)          w = 32'h8000_0000;
      else if (g == 16 * nb - 1) w = 32'(32 * n);
      else                      w = 32'h0000_0000;
      r[511 - 32 * j -: 32] = w;
    end
    return r;
  endfunction

  task automatic applyStimulus(input int which, input logic [15:0] addr);
    sel     = which;
    addr_in = addr;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int expected);
    int cnt;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!valid_w[sel] && cnt < 40);
    chk32({tag, " latency"}, 32'(cnt), 32'(expected));
  endtask

  task automatic checkBlock(input string tag, input int blk,
                            input logic [15:0] base, input logic last,
                            input int latency);
    waitValid(tag, latency);
    checkOutput({tag, " data"}, data_w[sel],
                expBlock(n_of[sel], nb_of[sel], base, blk));
    chk1({tag, " last"}, last_w[sel], last);
  endtask

  task automatic handshakeMid(input string tag);
    step();
    chk1({tag, " valid drop"}, valid_w[sel], 1'b0);
    chk1({tag, " busy mid"}, busy_w[sel], 1'b1);
  endtask

  task automatic handshakeFinal(input string tag);
    step();
    chk1({tag, " valid drop"}, valid_w[sel], 1'b0);
    chk1({tag, " done pulse"}, done_w[sel], 1'b1);
    step();
    chk1({tag, " done clear"}, done_w[sel], 1'b0);
    chk1({tag, " busy clear"}, busy_w[sel], 1'b0);
  endtask

  // Directed sequence covering reset, three message lengths, backpressure,
  // mid-message reset and address wrap with an ignored restart.
  initial begin
    int pulses;
    rst_n   = 1'b0;
    start   = 1'b0;
    ready   = 1'b1;
    addr_in = '0;
    sel     = 0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk1("reset busy", busy_w[i], 1'b0);
      chk1("reset done", done_w[i], 1'b0);
      chk1("reset valid", valid_w[i], 1'b0);
      chk1("reset last", last_w[i], 1'b0);
      checkOutput("reset data", data_w[i], 512'd0);
      chk32("reset addr", {16'h0000, maddr_w[i]}, 32'h0);
      chk1("enable_write", we_w[i], 1'b0);
    end
    chk1("memory_clk", mclk_w[0], clk);
    rst_n = 1'b1;
    step();

    // N=40, three blocks
    applyStimulus(0, 16'h0100);
    checkBlock("t1 blk0", 0, 16'h0100, 1'b0, 18);
    chk32("t1 blk0 w0", wordOf(data_w[0], 0), 32'h0000_0100);
    handshakeMid("t1 blk0");
    checkBlock("t1 blk1", 1, 16'h0100, 1'b0, 18);
    chk32("t1 blk1 w15", wordOf(data_w[0], 15), 32'h0000_011F);
    handshakeMid("t1 blk1");
    checkBlock("t1 blk2", 2, 16'h0100, 1'b1, 18);
    chk32("t1 blk2 w7", wordOf(data_w[0], 7), 32'h0000_0127);
    chk32("t1 blk2 w8", wordOf(data_w[0], 8), 32'h8000_0000);
    chk32("t1 blk2 w14", wordOf(data_w[0], 14), 32'h0000_0000);
    chk32("t1 blk2 w15", wordOf(data_w[0], 15), 32'h0000_0500);
    handshakeFinal("t1");

    // N=14, marker fits in block 0 but the length does not
    applyStimulus(1, 16'h0200);
    checkBlock("t2 blk0", 0, 16'h0200, 1'b0, 18);
    chk32("t2 blk0 w13", wordOf(data_w[1], 13), 32'h0000_020D);
    chk32("t2 blk0 w14", wordOf(data_w[1], 14), 32'h8000_0000);
    chk32("t2 blk0 w15", wordOf(data_w[1], 15), 32'h0000_0000);
    handshakeMid("t2 blk0");
    checkBlock("t2 blk1", 1, 16'h0200, 1'b1, 18);
    chk32("t2 blk1 w0", wordOf(data_w[1], 0), 32'h0000_0000);
    chk32("t2 blk1 w15", wordOf(data_w[1], 15), 32'h0000_01C0);
    handshakeFinal("t2");

    // N=16, block 0 is all message
    applyStimulus(2, 16'h0300);
    checkBlock("t3 blk0", 0, 16'h0300, 1'b0, 18);
    chk32("t3 blk0 w15", wordOf(data_w[2], 15), 32'h0000_030F);
    handshakeMid("t3 blk0");
    checkBlock("t3 blk1", 1, 16'h0300, 1'b1, 18);
    chk32("t3 blk1 w0", wordOf(data_w[2], 0), 32'h8000_0000);
    chk32("t3 blk1 w15", wordOf(data_w[2], 15), 32'h0000_0200);
    handshakeFinal("t3");

    // Backpressure on block 0
    ready = 1'b0;
    applyStimulus(2, 16'h0400);
    checkBlock("t4 blk0", 0, 16'h0400, 1'b0, 18);
    for (int c = 0; c < 5; c++) begin
      step();
      chk1("t4 hold valid", valid_w[2], 1'b1);
      checkOutput("t4 hold data", data_w[2], expBlock(16, 2, 16'h0400, 0));
      chk32("t4 hold addr", {16'h0000, maddr_w[2]}, 32'h0000_040F);
    end
    ready = 1'b1;
    handshakeMid("t4 blk0");
    checkBlock("t4 blk1", 1, 16'h0400, 1'b1, 18);
    handshakeFinal("t4");

    // Reset during FETCH of block 1, then restart from scratch
    applyStimulus(0, 16'h0100);
    checkBlock("t5 blk0", 0, 16'h0100, 1'b0, 18);
    handshakeMid("t5 blk0");
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0;
    step();
    chk1("t5 rst busy", busy_w[0], 1'b0);
    chk1("t5 rst valid", valid_w[0], 1'b0);
    chk1("t5 rst done", done_w[0], 1'b0);
    checkOutput("t5 rst data", data_w[0], 512'd0);
    rst_n = 1'b1;
    applyStimulus(0, 16'h0100);
    checkBlock("t5 re blk0", 0, 16'h0100, 1'b0, 18);
    handshakeMid("t5 re blk0");
    checkBlock("t5 re blk1", 1, 16'h0100, 1'b0, 18);
    handshakeMid("t5 re blk1");
    checkBlock("t5 re blk2", 2, 16'h0100, 1'b1, 18);
    handshakeFinal("t5");

    // Address wrap with a second start while busy
    applyStimulus(2, 16'hFFF8);
    for (int c = 0; c < 3; c++) step();
    addr_in = 16'h1234;
    start   = 1'b1;
    step();
    start   = 1'b0;
    checkBlock("t6 blk0", 0, 16'hFFF8, 1'b0, 14);
    chk32("t6 blk0 w7", wordOf(data_w[2], 7), 32'h0000_FFFF);
    chk32("t6 blk0 w8", wordOf(data_w[2], 8), 32'h0000_0000);
    chk32("t6 blk0 w15", wordOf(data_w[2], 15), 32'h0000_0007);
    handshakeMid("t6 blk0");
    checkBlock("t6 blk1", 1, 16'hFFF8, 1'b1, 18);
    step();
    pulses = done_w[2] ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done_w[2]) pulses++;
    end
    chk32("t6 done pulses", 32'(pulses), 32'd1);
    chk1("t6 busy end", busy_w[2], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
